// File: rtl/otter_iobus_harness_pkg.sv
// Shared types and constants for the OTTER IOBUS stimulus/capture harness.
package otter_harness_pkg;

    // Reset sequencer states: CPU held in reset, then released to run.
    typedef enum logic {HOLD, RUN} hrn_state_t;

    // One logged CPU IOBUS write.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } cap_entry_t;

    localparam logic [31:0] DefaultBaseAddr = 32'h1100_0000;
    localparam int unsigned CapEntryWidth   = $bits(cap_entry_t);

endpackage

// File: rtl/otter_iobus_harness_if.sv
// IOBUS and capture-port bundle between the OTTER side (master) and the harness (slave).
interface otter_iobus_harness_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DEPTH  = 16
);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic                   cpu_rst;
    logic                   boot_done;
    logic [31:0]            iobus_addr;
    logic [31:0]            iobus_out;
    logic                   iobus_wr;
    logic [31:0]            iobus_in;
    logic [NUM_CH*32-1:0]   ch_data;
    logic                   cap_rd;
    logic                   cap_valid;
    logic [31:0]            cap_addr;
    logic [31:0]            cap_data;
    logic [CntW-1:0]        cap_count;
    logic                   cap_ovf;

    modport master (
        output iobus_addr, iobus_out, iobus_wr, ch_data, cap_rd,
        input  cpu_rst, boot_done, iobus_in, cap_valid, cap_addr, cap_data, cap_count, cap_ovf
    );

    modport slave (
        input  iobus_addr, iobus_out, iobus_wr, ch_data, cap_rd,
        output cpu_rst, boot_done, iobus_in, cap_valid, cap_addr, cap_data, cap_count, cap_ovf
    );

endinterface

// File: rtl/otter_iobus_harness_fifo.sv
// Synchronous first-word-fall-through FIFO; head is always visible on rdata_o.
module harness_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem[rd_ptr_q];

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/otter_iobus_harness.sv
// OTTER IOBUS harness: CPU reset sequencer, memory-mapped input channels, write capture log.
module otter_iobus_harness
    import otter_harness_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter logic [31:0] BASE_ADDR  = DefaultBaseAddr,
    parameter int unsigned RST_CYCLES = 3,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    otter_iobus_harness_if.slave  bus
);
    localparam int unsigned HoldW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    hrn_state_t       state_q;
    logic [HoldW-1:0] hold_cnt_q;
    logic             cpu_rst_q;
    logic             boot_done_q;
    logic             cap_ovf_q;

    logic [31:0]      rd_off;
    logic             rd_hit;

    logic             push_req;
    logic             pop_req;
    logic             fifo_full;
    logic             fifo_empty;
    cap_entry_t       wr_entry;
    cap_entry_t       rd_entry;

    // Reset sequencer: hold the CPU for RST_CYCLES cycles, then release it for good.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HOLD;
            hold_cnt_q  <= '0;
            cpu_rst_q   <= 1'b1;
            boot_done_q <= 1'b0;
        end else begin
            case (state_q)
                HOLD: begin
                    hold_cnt_q <= hold_cnt_q + HoldW'(1);
                    if (hold_cnt_q == HoldW'(RST_CYCLES - 1)) begin
                        state_q     <= RUN;
                        cpu_rst_q   <= 1'b0;
                        boot_done_q <= 1'b1;
                    end
                end
                RUN: state_q <= RUN;
            endcase
        end
    end

    assign bus.cpu_rst   = cpu_rst_q;
    assign bus.boot_done = boot_done_q;

    // Zero-latency channel read mux; anything unmapped, misaligned or in HOLD reads 0.
    always_comb begin
        rd_off       = bus.iobus_addr - BASE_ADDR;
        rd_hit       = (state_q == RUN) && (bus.iobus_addr[1:0] == 2'b00) &&
                       (bus.iobus_addr >= BASE_ADDR) && (rd_off < 32'(4 * NUM_CH));
        bus.iobus_in = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rd_hit && (rd_off[31:2] == 30'(k))) begin
                bus.iobus_in = bus.ch_data[32*k +: 32];
            end
        end
    end

    assign push_req      = bus.iobus_wr & (state_q == RUN);
    assign pop_req       = bus.cap_rd & ~fifo_empty;
    assign wr_entry.addr = bus.iobus_addr;
    assign wr_entry.data = bus.iobus_out;

    harness_fifo #(
        .WIDTH (CapEntryWidth),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push_req),
        .wdata_i (wr_entry),
        .pop_i   (pop_req),
        .rdata_o (rd_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (bus.cap_count)
    );

    // Sticky overflow: a write was lost because the log was full and nothing left.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_ovf_q <= 1'b0;
        end else if (push_req && fifo_full && !pop_req) begin
            cap_ovf_q <= 1'b1;
        end
    end

    assign bus.cap_ovf   = cap_ovf_q;
    assign bus.cap_valid = ~fifo_empty;
    assign bus.cap_addr  = rd_entry.addr;
    assign bus.cap_data  = rd_entry.data;

endmodule

// File: tb/tb_otter_iobus_harness.sv
// Directed bench for otter_iobus_harness with default parameters.
module tb_otter_iobus_harness;

    localparam logic [31:0] BASE = 32'h1100_0000;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    otter_iobus_harness_if #(.NUM_CH(4), .DEPTH(16)) bus ();

    otter_iobus_harness #(
        .NUM_CH     (4),
        .BASE_ADDR  (BASE),
        .RST_CYCLES (3),
        .DEPTH      (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic rd);
        bus.iobus_addr = a;
        bus.iobus_out  = d;
        bus.iobus_wr   = 1'b1;
        bus.cap_rd     = rd;
        tick();
        bus.iobus_wr   = 1'b0;
        bus.cap_rd     = 1'b0;
    endtask

    task automatic do_pop();
        bus.cap_rd = 1'b1;
        tick();
        bus.cap_rd = 1'b0;
    endtask

    task automatic wait_boot();
        for (int i = 0; i < 20 && bus.boot_done !== 1'b1; i++) tick();
        n_tests++;
        if (bus.boot_done !== 1'b1) begin
            n_fail++;
            $display("FAIL boot_timeout: boot_done=%b required 1", bus.boot_done);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        wait_boot();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.iobus_addr = BASE;
        tick();
        tick();
        n_tests++;
        if (bus.cpu_rst !== 1'b1 || bus.boot_done !== 1'b0 || bus.cap_count !== 5'd0 ||
            bus.cap_valid !== 1'b0 || bus.cap_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: cpu_rst=%b boot=%b cnt=%0d valid=%b ovf=%b required 1 0 0 0 0",
                     bus.cpu_rst, bus.boot_done, bus.cap_count, bus.cap_valid, bus.cap_ovf);
        end
        n_tests++;
        if (bus.iobus_in !== 32'h0) begin
            n_fail++;
            $display("FAIL read_in_reset: iobus_in=%h required 0", bus.iobus_in);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (bus.cpu_rst !== 1'b1 || bus.boot_done !== 1'b0 || bus.cap_count !== 5'd0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: cpu_rst=%b boot=%b cnt=%0d required 1 0 0",
                         i, bus.cpu_rst, bus.boot_done, bus.cap_count);
            end
            tick();
        end
        n_tests++;
        if (bus.cpu_rst !== 1'b0 || bus.boot_done !== 1'b1 || bus.cap_count !== 5'd0) begin
            n_fail++;
            $display("FAIL release: cpu_rst=%b boot=%b cnt=%0d required 0 1 0",
                     bus.cpu_rst, bus.boot_done, bus.cap_count);
        end
    endtask

    task automatic test_read_decode();
        logic [31:0] addrs [6];
        logic [31:0] exps  [6];
        addrs = '{BASE, BASE + 32'd4, BASE + 32'd12, BASE + 32'd16, BASE + 32'd2, BASE - 32'd4};
        exps  = '{32'h2, 32'h11, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 6; i++) begin
            bus.iobus_addr = addrs[i];
            #1;
            n_tests++;
            if (bus.iobus_in !== exps[i]) begin
                n_fail++;
                $display("FAIL read_addr_%h: iobus_in=%h required %h", addrs[i], bus.iobus_in,
                         exps[i]);
            end
        end
        rst = 1'b1;
        bus.iobus_addr = BASE + 32'd12;
        tick();
        n_tests++;
        if (bus.iobus_in !== 32'h0) begin
            n_fail++;
            $display("FAIL read_in_hold: iobus_in=%h required 0", bus.iobus_in);
        end
        rst = 1'b0;
        wait_boot();
    endtask

    task automatic test_capture_order();
        for (int i = 0; i < 3; i++) do_write(BASE + 32'h20 + 32'(4 * i), 32'(i + 1), 1'b0);
        n_tests++;
        if (bus.cap_count !== 5'd3 || bus.cap_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL cap_fill: cnt=%0d valid=%b required 3 1", bus.cap_count, bus.cap_valid);
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (bus.cap_addr !== BASE + 32'h20 + 32'(4 * i) || bus.cap_data !== 32'(i + 1)) begin
                n_fail++;
                $display("FAIL cap_head%0d: addr=%h data=%h required %h %h", i, bus.cap_addr,
                         bus.cap_data, BASE + 32'h20 + 32'(4 * i), i + 1);
            end
            do_pop();
            n_tests++;
            if (bus.cap_count !== 5'(2 - i)) begin
                n_fail++;
                $display("FAIL cap_count_pop%0d: cnt=%0d required %0d", i, bus.cap_count, 2 - i);
            end
        end
        n_tests++;
        if (bus.cap_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL cap_empty: valid=%b required 0", bus.cap_valid);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp;
        for (int i = 0; i < 17; i++) do_write(BASE + 32'(4 * i), 32'(i), 1'b0);
        n_tests++;
        if (bus.cap_count !== 5'd16 || bus.cap_ovf !== 1'b1 || bus.cap_data !== 32'd0) begin
            n_fail++;
            $display("FAIL ovf_full: cnt=%0d ovf=%b head=%h required 16 1 0", bus.cap_count,
                     bus.cap_ovf, bus.cap_data);
        end
        do_write(BASE + 32'h100, 32'd100, 1'b1);
        n_tests++;
        if (bus.cap_count !== 5'd16 || bus.cap_data !== 32'd1) begin
            n_fail++;
            $display("FAIL full_push_pop: cnt=%0d head=%h required 16 1", bus.cap_count,
                     bus.cap_data);
        end
        for (int i = 0; i < 16; i++) begin
            exp = (i < 15) ? 32'(i + 1) : 32'd100;
            n_tests++;
            if (bus.cap_data !== exp) begin
                n_fail++;
                $display("FAIL ovf_drain%0d: data=%h required %h", i, bus.cap_data, exp);
            end
            do_pop();
        end
        n_tests++;
        if (bus.cap_count !== 5'd0 || bus.cap_valid !== 1'b0 || bus.cap_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_after_drain: cnt=%0d valid=%b ovf=%b required 0 0 1",
                     bus.cap_count, bus.cap_valid, bus.cap_ovf);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        n_tests++;
        if (bus.cap_ovf !== 1'b0 || bus.cap_count !== 5'd0) begin
            n_fail++;
            $display("FAIL ovf_cleared: ovf=%b cnt=%0d required 0 0", bus.cap_ovf, bus.cap_count);
        end
        // Push and pop together on an empty log: the pop is ignored.
        do_write(BASE, 32'd0, 1'b1);
        n_tests++;
        if (bus.cap_count !== 5'd1 || bus.cap_data !== 32'd0) begin
            n_fail++;
            $display("FAIL empty_push_pop: cnt=%0d head=%h required 1 0", bus.cap_count,
                     bus.cap_data);
        end
        for (int i = 1; i <= 40; i++) begin
            n_tests++;
            if (bus.cap_data !== 32'(i - 1)) begin
                n_fail++;
                $display("FAIL wrap_head%0d: data=%h required %h", i, bus.cap_data, i - 1);
            end
            do_write(BASE + 32'(4 * (i % 8)), 32'(i), 1'b1);
            n_tests++;
            if (bus.cap_count !== 5'd1) begin
                n_fail++;
                $display("FAIL wrap_count%0d: cnt=%0d required 1", i, bus.cap_count);
            end
        end
        n_tests++;
        if (bus.cap_data !== 32'd40 || bus.cap_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_end: head=%h ovf=%b required 28 0", bus.cap_data, bus.cap_ovf);
        end
        do_pop();
    endtask

    task automatic test_mid_run_reset();
        for (int i = 0; i < 5; i++) do_write(BASE + 32'(4 * i), 32'(i + 7), 1'b0);
        n_tests++;
        if (bus.cap_count !== 5'd5) begin
            n_fail++;
            $display("FAIL mid_prefill: cnt=%0d required 5", bus.cap_count);
        end
        rst            = 1'b1;
        bus.iobus_addr = BASE + 32'h40;
        bus.iobus_out  = 32'hABCD;
        bus.iobus_wr   = 1'b1;
        tick();
        rst = 1'b0;
        // Keep writing through HOLD; none of it may be logged.
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (bus.cpu_rst !== 1'b1 || bus.cap_count !== 5'd0 || bus.cap_valid !== 1'b0 ||
                bus.cap_ovf !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_hold%0d: cpu_rst=%b cnt=%0d valid=%b ovf=%b required 1 0 0 0",
                         i, bus.cpu_rst, bus.cap_count, bus.cap_valid, bus.cap_ovf);
            end
            tick();
        end
        bus.iobus_wr = 1'b0;
        n_tests++;
        if (bus.cpu_rst !== 1'b0 || bus.boot_done !== 1'b1 || bus.cap_count !== 5'd0) begin
            n_fail++;
            $display("FAIL mid_release: cpu_rst=%b boot=%b cnt=%0d required 0 1 0",
                     bus.cpu_rst, bus.boot_done, bus.cap_count);
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.iobus_addr = '0;
        bus.iobus_out  = '0;
        bus.iobus_wr   = 1'b0;
        bus.cap_rd     = 1'b0;
        bus.ch_data    = {32'hDEAD_BEEF, 32'h22, 32'h11, 32'h2};
        test_reset();
        test_read_decode();
        test_capture_order();
        test_overflow();
        test_wrap();
        test_mid_run_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

endmodule
